multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main sequencer for the multicycle ARM datapath.
- Drives the IR and PC enables, the datapath mux selects, ALU-op request, and the raw PCS/RegW/MemW strobes that cond_logic gates with CondEx.
- Moore FSM on the instruction's Op/Funct fields, plus a fetched-instruction counter for performance debug.
- Sits between the instruction register and the cond_logic / ALU decoder.

Parameters:
CNT_W, 32, width of the fetched-instruction counter instr_cnt.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
Op  in  2  instruction bits [27:26]
Funct  in  6  instruction bits [25:20]; Funct[5]=I, Funct[0]=L/S
mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN)
IRWrite  out  1  load instruction register
NextPC  out  1  PC update request (ORed with PCSrc externally)
AdrSrc  out  1  0 = PC, 1 = ALUResult register as memory address
ALUSrcA  out  1  0 = RD1 register, 1 = PC
ALUSrcB  out  2  00 = RD2 reg, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUOp  out  1  1 = ALU decoder uses Funct; 0 = add
RegW  out  1  raw register-write strobe to cond_logic
MemW  out  1  raw memory-write strobe to cond_logic
Branch  out  1  raw PCS strobe to cond_logic
state  out  4  current state encoding (debug)
instr_cnt  out  CNT_W  number of instructions fetched

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE
  - DECODE:
    - Op=00, Funct[5]=0 -> EXECR
    - Op=00, Funct[5]=1 -> EXECI
    - Op=01 -> MEMADR
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (undefined instruction; no strobes)
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR
  - MEMRD -> MEMWB
  - EXECR and EXECI -> ALUWB
  - MEMWB, MEMWR, ALUWB and BRANCH -> FETCH
- Outputs are Moore-decoded from state. Any signal not listed below is 0.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0
  - MEMRD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1
- Latency without wait states:
  - branch: 3 cycles
  - data processing: 4 cycles
  - STR: 4 cycles
  - LDR: 5 cycles
  - undefined: 2 cycles
- Op and Funct are sampled only in DECODE and MEMADR. They must be stable from the IR in those cycles.
- instr_cnt increments by 1 on every rising edge where IRWrite=1. It wraps from 2^CNT_W-1 to 0.
- Reset (reset=0, asynchronous):
  - state=FETCH, instr_cnt=0.
  - IRWrite, NextPC, RegW, MemW and Branch are forced to 0 for as long as reset=0.
  - Selects show their FETCH values.
- Reset asserted mid-instruction aborts immediately. No partial strobe appears after reset asserts. The first edge after release executes FETCH.
- Strobes are raw. Conditional suppression is done solely by cond_logic. This block never inspects flags.

Optional Feature:
Macro MEM_WAIT_EN.
- Defined:
  - FETCH, MEMRD and MEMWR hold their state until a rising edge with mem_ready=1.
  - In FETCH, IRWrite and NextPC are asserted only in cycles where mem_ready=1. instr_cnt therefore counts once per instruction.
  - In MEMWR, MemW stays asserted for every cycle in that state.
  - All other states ignore mem_ready.
- Not defined:
  - mem_ready is ignored (port still present).
  - Every state lasts exactly one cycle, as in the latency table.

Test Plan:
- Reset low for 3 cycles, then high → strobes 0 during reset. state=0 and instr_cnt=0 at release. IRWrite=1 in the first cycle after release.
- ADD reg (Op=00, Funct=000000) → state sequence 0,1,6,8,0. RegW=1 only in ALUWB. ALUOp=1 in EXECR. instr_cnt +1.
- LDR (Op=01, Funct=011001) then STR (Op=01, Funct=011000) → 0,1,2,3,4,0 then 0,1,2,5,0. MemW=1 only in MEMWR. ResultSrc=01 in MEMWB.
- B (Op=10) and undefined (Op=11) → 0,1,9,0 with Branch=1 only in BRANCH. Undefined gives 0,1,0 with no RegW/MemW/Branch.
- Reset asserted in EXECI → state=0 and RegW=0 asynchronously. ALUWB is never entered.
- With MEM_WAIT_EN, LDR with mem_ready low 2 cycles in FETCH and MEMRD:
  - FETCH lasts 3 cycles, IRWrite high only in its last cycle.
  - MEMRD lasts 3 cycles.
  - instr_cnt +1 exactly.
  - With CNT_W=4 preset by 15 fetches, the next fetch wraps instr_cnt to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main sequencer for the multicycle ARM datapath.
//
// A Moore FSM walks each instruction through fetch, decode and execute. The
// Op/Funct fields are looked at only in DECODE and MEMADR. From the current
// state the block drives:
//   - the IR and PC enables,
//   - the datapath mux selects,
//   - the ALU-op request,
//   - the raw Branch/RegW/MemW strobes.
// cond_logic later gates those strobes with CondEx; this block never looks at
// flags. A fetched-instruction counter supports performance debug.
//
// Optional build macro: MEM_WAIT_EN
//   Defined    : FETCH, MEMRD and MEMWR stall until an edge with mem_ready=1.
//                In FETCH, IRWrite and NextPC are qualified by mem_ready.
//   Undefined  : mem_ready is ignored and every state lasts one cycle.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   Op         in   2      instruction bits [27:26]
//   Funct      in   6      instruction bits [25:20] (Funct[5]=I, Funct[0]=L)
//   mem_ready  in   1      memory access complete (MEM_WAIT_EN only)
//   IRWrite    out  1      load instruction register
//   NextPC     out  1      PC update request
//   AdrSrc     out  1      0 = PC, 1 = ALUResult register as address
//   ALUSrcA    out  1      0 = RD1 register, 1 = PC
//   ALUSrcB    out  2      00 = RD2, 01 = ExtImm, 10 = constant 4
//   ResultSrc  out  2      00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUOp      out  1      1 = ALU decoder uses Funct, 0 = add
//   RegW       out  1      raw register-write strobe
//   MemW       out  1      raw memory-write strobe
//   Branch     out  1      raw PCS strobe
//   state      out  4      current state encoding (debug)
//   instr_cnt  out  CNT_W  instructions fetched (wraps)
//
// Handshake: mem_ready is a level qualifier. A stalled state advances on the
// first rising edge that sees mem_ready=1, and that edge also completes the
// access. There is no separate request signal.

module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t cur;
    logic   mem_go;
    logic   irwrite_raw, nextpc_raw, regw_raw, memw_raw, branch_raw;

    // Only Funct[5] (I) and Funct[0] (L) steer the sequence.
    logic [3:0] unused_funct;
    assign unused_funct = Funct[4:1];

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    assign state = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= S_FETCH;
            instr_cnt <= '0;
        end else begin
            if (IRWrite)
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            case (cur)
                S_FETCH:  if (mem_go) cur <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        2'b00:   cur <= Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   cur <= S_MEMADR;
                        2'b10:   cur <= S_BRANCH;
                        default: cur <= S_FETCH;   // undefined: no strobes
                    endcase
                end
                S_MEMADR: cur <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_go) cur <= S_MEMWB;
                S_MEMWR:  if (mem_go) cur <= S_FETCH;
                S_EXECR,
                S_EXECI:  cur <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH: cur <= S_FETCH;
                default:  cur <= S_FETCH;          // illegal codes 10-15
            endcase
        end
    end

    // Moore output decode. The selects keep their FETCH values during reset,
    // because the state register sits at FETCH.
    always_comb begin
        irwrite_raw = 1'b0;
        nextpc_raw  = 1'b0;
        regw_raw    = 1'b0;
        memw_raw    = 1'b0;
        branch_raw  = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUOp       = 1'b0;
        case (cur)
            S_FETCH: begin
                irwrite_raw = mem_go;
                nextpc_raw  = mem_go;
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw_raw  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                memw_raw = 1'b1;
            end
            S_EXECR:  ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB:  regw_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                branch_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are held low while reset is asserted. Asserting reset in the
    // middle of an instruction therefore cannot leak a partial strobe.
    assign IRWrite = reset & irwrite_raw;
    assign NextPC  = reset & nextpc_raw;
    assign RegW    = reset & regw_raw;
    assign MemW    = reset & memw_raw;
    assign Branch  = reset & branch_raw;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  // Observation vector:
  // {state, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch}
  localparam logic [15:0] V_FETCH  = 16'h0DA0;
  localparam logic [15:0] V_RESET  = 16'h01A0;  // FETCH selects, strobes low
  localparam logic [15:0] V_DECODE = 16'h11A0;
  localparam logic [15:0] V_MEMADR = 16'h2040;
  localparam logic [15:0] V_MEMRD  = 16'h3200;
  localparam logic [15:0] V_MEMWB  = 16'h4014;
  localparam logic [15:0] V_MEMWR  = 16'h5202;
  localparam logic [15:0] V_EXECR  = 16'h6008;
  localparam logic [15:0] V_EXECI  = 16'h7048;
  localparam logic [15:0] V_ALUWB  = 16'h8004;
  localparam logic [15:0] V_BRANCH = 16'h9061;

`ifdef MEM_WAIT_EN
  localparam logic MR_IDLE = 1'b1;
`else
  localparam logic MR_IDLE = 1'b0;  // shows mem_ready is ignored
`endif

  logic             clk;
  logic             reset;
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             mem_ready;
  logic             IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch;
  logic [1:0]       ALUSrcB, ResultSrc;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic [15:0]      obs;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_cnt;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .state(state), .instr_cnt(instr_cnt)
  );

  assign obs = {state, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ALUOp, RegW, MemW, Branch};

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Each test starts just after a rising edge with the DUT in FETCH.
  // It ends at the same point, one instruction (or more) later.
  task automatic test_reset();
    reset = 1'b0; Op = 2'b00; Funct = 6'd0; mem_ready = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== V_RESET || instr_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: obs=%h cnt=%0d, want obs=%h cnt=%0d", i, obs, instr_cnt, V_RESET, exp_cnt);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = MR_IDLE;
    #1;
    checks++;
    if (obs !== V_FETCH || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL reset_release: obs=%h cnt=%0d, want obs=%h cnt=%0d", obs, instr_cnt, V_FETCH, exp_cnt);
    end
  endtask

  task automatic test_add();
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    exp_q = {V_FETCH, V_DECODE, V_EXECR, V_ALUWB};
    Op = 2'b00; Funct = 6'b000000; mem_ready = MR_IDLE;
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL add cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL add_end: state=%0d cnt=%0d, want state=0 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_ldr_str();
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    // LDR
    exp_q = {V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    Op = 2'b01; Funct = 6'b011001; mem_ready = MR_IDLE;
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ldr cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    // STR
    exp_q = {V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
    Funct = 6'b011000;
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL str cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 2'd2;
    checks++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL ldr_str_end: state=%0d cnt=%0d, want state=0 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_branch_undef();
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    exp_q = {V_FETCH, V_DECODE, V_BRANCH};
    Op = 2'b10; Funct = 6'b101010; mem_ready = MR_IDLE;
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL branch cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    exp_q = {V_FETCH, V_DECODE};
    Op = 2'b11; Funct = 6'b111111;
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL undef cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 2'd2;
    checks++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL branch_undef_end: state=%0d cnt=%0d, want state=0 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  // LDR with mem_ready low for 2 cycles in FETCH and in MEMRD, then STR with
  // mem_ready low for 1 cycle in MEMWR. Without MEM_WAIT_EN the low cycles
  // must have no effect.
  task automatic test_mem_wait();
    logic [15:0] exp_q[$];
    logic        mr_q[$];
    logic [15:0] exp;
    Op = 2'b01; Funct = 6'b011001;
`ifdef MEM_WAIT_EN
    mr_q  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q = {V_RESET, V_RESET, V_FETCH, V_DECODE, V_MEMADR,
             V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
`else
    mr_q  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_q = {V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
`endif
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mem_wait_ldr cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    Funct = 6'b011000;
`ifdef MEM_WAIT_EN
    mr_q  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_q = {V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR};
`else
    mr_q  = {1'b0, 1'b0, 1'b0, 1'b0};
    exp_q = {V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
`endif
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mem_wait_str cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    mem_ready = MR_IDLE;
    exp_cnt = exp_cnt + 2'd2;
    checks++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL mem_wait_end: state=%0d cnt=%0d, want state=0 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    exp_q = {V_FETCH, V_DECODE};
    Op = 2'b00; Funct = 6'b100000; mem_ready = MR_IDLE;
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: obs=%h, want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (obs !== V_EXECI) begin
      errors++;
      $display("FAIL reset_mid_execi: obs=%h, want %h", obs, V_EXECI);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_RESET || instr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_async: obs=%h cnt=%0d, want obs=%h cnt=0", obs, instr_cnt, V_RESET);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== V_RESET) begin
      errors++;
      $display("FAIL reset_mid_no_aluwb: obs=%h, want %h", obs, V_RESET);
    end
    reset = 1'b1;
    exp_cnt = '0;
    #1;
    checks++;
    if (obs !== V_FETCH || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL reset_mid_release: obs=%h cnt=%0d, want obs=%h cnt=0", obs, instr_cnt, V_FETCH);
    end
  endtask

  // Undefined instructions are the shortest fetch loop (2 cycles each).
  task automatic test_cnt_wrap();
    Op = 2'b11; Funct = 6'd0; mem_ready = MR_IDLE;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1'b1;
    end
    checks++;
    if (instr_cnt !== exp_cnt || state !== 4'd0) begin
      errors++;
      $display("FAIL cnt_preset: cnt=%0d state=%0d, want cnt=%0d state=0", instr_cnt, state, exp_cnt);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (instr_cnt !== exp_cnt || instr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cnt_wrap: cnt=%0d, want cnt=%0d", instr_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_str();
    test_branch_undef();
    test_mem_wait();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
